hazard_unit_md: RTL
===================

# hazard_unit_md

Next-generation hazard detection and forwarding unit for the 5-stage pipelined MIPS core, extended with a multi-cycle multiply/divide (MDU) tracker. Parametrised in register-address width and MDU latencies. Combinationally resolves load-use, branch, jump-register and HI/LO hazards, and sequentially tracks the MDU busy window. Sits beside the datapath, driving the IF/ID/EX pipeline-register stall/flush controls and the forwarding muxes.

## Interface
- RF_ADDR_WIDTH, 5, register-file address width
- MUL_CYCLES, 4, MDU cycles for MULT/MULTU (≥2)
- DIV_CYCLES, 32, MDU cycles for DIV/DIVU (≥2)
- CNT_WIDTH, 32, performance-counter width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- BranchD, JD, JrD, ALUSrcD  in  1 each  decode-stage control: conditional branch, J/JAL, JR/JALR, immediate operand
- MdOpD  in  1  MULT/DIV family instruction in Decode
- MfhiloD  in  1  MFHI/MFLO in Decode
- MdStartE, MdDivE  in  1 each  MDU op in Execute; 1 = divide, 0 = multiply
- RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW  in  RF_ADDR_WIDTH each  register specifiers
- RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM  in  1 each  pipeline control
- StallF, StallD, FlushE  out  1 each  pipeline controls; FlushE = StallD
- ForwardAD, ForwardBD  out  1 each  branch/JR comparator forward from ALUOutM
- ForwardAE, ForwardBE  out  2 each  ALU source select: 0 RF, 1 ResultW, 2 ALUOutM
- MdBusy  out  1  MDU operation in flight
- HiLoWe  out  1  one-cycle HI/LO write strobe to the MDU result registers

## Operation
- Forwarding: a source in E matching WriteRegM with RegWriteM selects 2; else matching WriteRegW with RegWriteW selects 1; else 0. Register 0 never forwards. M wins when both match.
- Branch forwarding: ForwardAD/BD = RegWriteM, RsD/RtD nonzero and equal to WriteRegM.
- lwstall: MemtoRegE and (RsD==RtE, or RtD==RtE with !ALUSrcD and !JrD), specifiers nonzero, suppressed by JD.
- branchstall: BranchD and a nonzero RsD/RtD matches WriteRegE (RegWriteE) or WriteRegM (MemtoRegM).
- jrstall: JrD with the same test on RsD only.
- mdstall: (MfhiloD or MdOpD) and (MdStartE or (state BUSY and cnt≠0)).
- StallF = StallD = FlushE = lwstall | branchstall | jrstall | mdstall.
- MDU FSM, states IDLE and BUSY, down-counter cnt of width clog2(DIV_CYCLES):
  - IDLE with MdStartE: load cnt = (MdDivE ? DIV_CYCLES : MUL_CYCLES) − 1, go to BUSY.
  - BUSY with cnt≠0: decrement cnt.
  - BUSY with cnt==0: go to IDLE.
  - MdStartE while BUSY cannot occur because mdstall blocks it. If it does occur, it is ignored: no reload.
- MdBusy = (state==BUSY). HiLoWe = BUSY and cnt==0.

## Timing
- All hazard outputs are combinational from current inputs and state; there is no added latency.
- If MdStartE is high in cycle t, BUSY covers cycles t+1 … t+N with N = the selected latency, and HiLoWe pulses in cycle t+N.
- MFHI in Decode during cycle t+N does not stall, because HI/LO is written at the end of that cycle.
- Reset at any time, including mid-operation: state IDLE, cnt 0, MdBusy 0, HiLoWe 0, counters 0. All combinational outputs follow their inputs.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs StallCnt and MdStallCnt (CNT_WIDTH each).
  - StallCnt increments on every cycle with StallF high.
  - MdStallCnt increments on every cycle with mdstall high.
  - Both wrap at 2^CNT_WIDTH and clear on rst.
- HAZARD_PERF_CNT_EN undefined: the ports and registers do not exist.

## Structure
- Shared package hazard_pkg:
  - md_state_t enum {MD_IDLE, MD_BUSY}
  - FWD_RF=2'd0, FWD_RESULTW=2'd1, FWD_ALUOUTM=2'd2
- Sub-module hazard_md_tracker holds the FSM, cnt, MdBusy and HiLoWe. The top level holds the combinational hazard logic and the optional counters.

## Test plan
- RegWriteM, WriteRegM=8, RsE=8 and RegWriteW, WriteRegW=8 -> ForwardAE=2. With RsE=0 -> ForwardAE=0.
- MemtoRegE, RtE=9, RsD=9 -> StallF=StallD=FlushE=1. Add JD=1 -> all 0.
- BranchD, RsD=4, RegWriteE, WriteRegE=4 -> stall. Next cycle RegWriteM, WriteRegM=4 -> no stall, ForwardAD=1.
- MdStartE, MdDivE=0, MUL_CYCLES=4 at t; MfhiloD held from t -> stall in t..t+3, no stall at t+4, HiLoWe only at t+4.
- Divide start, then rst asserted at t+5 -> MdBusy=0 asynchronously; MfhiloD gives no stall after reset.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls + 31 MDU stalls -> StallCnt=34, MdStallCnt=31.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit and its MDU tracker.
// Forwarding selects match the ALU source mux encoding in the datapath.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_RESULTW = 2'd1;
  localparam logic [1:0] FWD_ALUOUTM = 2'd2;

endpackage

// File: rtl/hazard_unit_md_if.sv
// Pipeline-control bundle between the datapath (master) and the hazard unit (slave).
// All fields are single-cycle qualified; the hazard unit answers combinationally.
interface hazard_unit_md_if #(
  parameter int RF_ADDR_WIDTH = 5
);

  logic                     BranchD, JD, JrD, ALUSrcD;
  logic                     MdOpD, MfhiloD;
  logic                     MdStartE, MdDivE;
  logic [RF_ADDR_WIDTH-1:0] RsD, RtD, RsE, RtE;
  logic [RF_ADDR_WIDTH-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic                     RegWriteE, RegWriteM, RegWriteW;
  logic                     MemtoRegE, MemtoRegM;

  logic                     StallF, StallD, FlushE;
  logic                     ForwardAD, ForwardBD;
  logic [1:0]               ForwardAE, ForwardBE;
  logic                     MdBusy, HiLoWe;

  modport master (
    output BranchD, JD, JrD, ALUSrcD, MdOpD, MfhiloD, MdStartE, MdDivE,
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    input  MdBusy, HiLoWe
  );

  modport slave (
    input  BranchD, JD, JrD, ALUSrcD, MdOpD, MfhiloD, MdStartE, MdDivE,
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    output MdBusy, HiLoWe
  );

endinterface

// File: rtl/hazard_md_tracker.sv
// MDU busy-window tracker: a start in cycle t keeps mdBusy high for t+1..t+N,
// with hiLoWe marking the final cycle t+N. Starts seen while busy are ignored.
module hazard_md_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mdStartE,
  input  logic mdDivE,
  output logic mdBusy,
  output logic hiLoWe
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  if (MUL_CYCLES < 2 || DIV_CYCLES < 2 || (MUL_CYCLES - 1) >= (2 ** CW)) begin : gBadLatency
    $error("hazard_md_tracker: MDU latencies must be >= 2 and fit the counter");
  end

  md_state_t     state, stateNext;
  logic [CW-1:0] cnt, cntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      MD_IDLE: begin
        if (mdStartE) begin
          stateNext = MD_BUSY;
          cntNext   = mdDivE ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) cntNext = cnt - CW'(1);
        else           stateNext = MD_IDLE;
      end
      default: begin
        stateNext = MD_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign mdBusy = (state == MD_BUSY);
  assign hiLoWe = mdBusy && (cnt == '0);

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard detection and forwarding for the 5-stage core plus MDU busy tracking; outputs are
// combinational. HAZARD_PERF_CNT_EN adds StallCnt/MdStallCnt stall counters.
module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_unit_md_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] MdStallCnt
`endif
);

  if (CNT_WIDTH < 1) begin : gBadCnt
    $error("hazard_unit_md: CNT_WIDTH must be positive");
  end

  // A producer only hazards a consumer on a real (nonzero) register it writes.
  function automatic logic regHit(input logic en, input logic [RF_ADDR_WIDTH-1:0] src,
                                  input logic [RF_ADDR_WIDTH-1:0] dst);
    return en && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [RF_ADDR_WIDTH-1:0] src);
    if (regHit(hz.RegWriteM, src, hz.WriteRegM))      return FWD_ALUOUTM;
    else if (regHit(hz.RegWriteW, src, hz.WriteRegW)) return FWD_RESULTW;
    else                                              return FWD_RF;
  endfunction

  logic mdBusy, hiLoWe;
  logic lwStall, branchStall, jrStall, mdStall, stall;

  hazard_md_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) uTracker (
    .clk      (clk),
    .rst      (rst),
    .mdStartE (hz.MdStartE),
    .mdDivE   (hz.MdDivE),
    .mdBusy   (mdBusy),
    .hiLoWe   (hiLoWe)
  );

  // Rt is only a source when the instruction uses it as a register operand.
  assign lwStall = hz.MemtoRegE && !hz.JD &&
                   (regHit(1'b1, hz.RsD, hz.RtE) ||
                    (!hz.ALUSrcD && !hz.JrD && regHit(1'b1, hz.RtD, hz.RtE)));

  assign branchStall = hz.BranchD &&
                       (regHit(hz.RegWriteE, hz.RsD, hz.WriteRegE) ||
                        regHit(hz.RegWriteE, hz.RtD, hz.WriteRegE) ||
                        regHit(hz.MemtoRegM, hz.RsD, hz.WriteRegM) ||
                        regHit(hz.MemtoRegM, hz.RtD, hz.WriteRegM));

  assign jrStall = hz.JrD &&
                   (regHit(hz.RegWriteE, hz.RsD, hz.WriteRegE) ||
                    regHit(hz.MemtoRegM, hz.RsD, hz.WriteRegM));

  // The HiLoWe cycle needs no stall: HI/LO is written at the end of it.
  assign mdStall = (hz.MfhiloD || hz.MdOpD) && (hz.MdStartE || (mdBusy && !hiLoWe));

  assign stall = lwStall || branchStall || jrStall || mdStall;

  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushE    = stall;
  assign hz.ForwardAD = regHit(hz.RegWriteM, hz.RsD, hz.WriteRegM);
  assign hz.ForwardBD = regHit(hz.RegWriteM, hz.RtD, hz.WriteRegM);
  assign hz.ForwardAE = fwdSel(hz.RsE);
  assign hz.ForwardBE = fwdSel(hz.RtE);
  assign hz.MdBusy    = mdBusy;
  assign hz.HiLoWe    = hiLoWe;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt   <= '0;
      MdStallCnt <= '0;
    end else begin
      if (stall)   StallCnt   <= StallCnt + CNT_WIDTH'(1);
      if (mdStall) MdStallCnt <= MdStallCnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
